// File: rtl/aes_round_key_bank.sv
// aes_round_key_bank: double-buffered AES round-key store fed by a one-hot key broadcast,
// with an atomic bank swap on load completion and a 1-cycle forward/inverse read port.
module aes_round_key_bank #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_W-1:0]      key_in,
  input  logic [NUM_ROUNDS:0]   set_key_onehot,
  input  logic                  zeroize,
  input  logic                  rd_en,
  input  logic [3:0]            rd_round,
  input  logic                  rd_inv,
  output logic [KEY_W-1:0]      rd_key,
  output logic                  rd_valid,
  output logic                  keys_ready,
  output logic                  load_busy,
  output logic                  load_err
);
  localparam int NK = NUM_ROUNDS + 1;
  localparam int IW = $clog2(NK);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t                          state_q, state_d;
  logic [IW-1:0]                   exp_q, exp_d, wr_idx, rd_idx;
  logic                            act_q, act_d, ready_q, ready_d, err_q, err_d;
  logic                            rd_valid_q, rd_valid_d, wr_en;
  logic [KEY_W-1:0]                rd_key_q, rd_key_d;
  logic [1:0][NK-1:0][KEY_W-1:0]   bank_q, bank_d;
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    act_d   = act_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    if (zeroize) begin
      state_d = IDLE;
      exp_d   = '0;
      act_d   = 1'b0;
      ready_d = 1'b0;
    end else if (set_key_onehot == NK'(1)) begin
      wr_en   = 1'b1;
      exp_d   = IW'(1);
      state_d = LOAD;
    end else if (state_q == LOAD && set_key_onehot == (NK'(1) << exp_q)) begin
      wr_en  = 1'b1;
      wr_idx = exp_q;
      exp_d  = exp_q + IW'(1);
      if (exp_q == IW'(NUM_ROUNDS)) begin
        act_d   = ~act_q;
        ready_d = 1'b1;
        state_d = IDLE;
        exp_d   = '0;
      end
    end else if (set_key_onehot != '0) begin
      err_d   = 1'b1;
      state_d = IDLE;
      exp_d   = '0;
    end
  end
  always_comb begin
    bank_d = bank_q;
    if (zeroize) bank_d = '0;
    else if (wr_en) bank_d[~act_q][wr_idx] = key_in;
  end
  // Read sees act_q before any same-edge swap, so a swap-cycle read returns the old set.
  always_comb begin
    rd_idx     = IW'(rd_inv ? 4'(NUM_ROUNDS) - rd_round : rd_round);
    rd_valid_d = rd_en && ready_q && rd_round <= 4'(NUM_ROUNDS) && !zeroize;
    rd_key_d   = rd_valid_d ? bank_q[act_q][rd_idx] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      act_q      <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      act_q      <= act_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_key_q   <= rd_key_d;
      bank_q     <= bank_d;
    end
  end
  assign rd_key     = rd_key_q;
  assign rd_valid   = rd_valid_q;
  assign keys_ready = ready_q;
  assign load_busy  = (state_q == LOAD);
  assign load_err   = err_q;
endmodule
